// File: rtl/recip_pkg.sv
// recip_pkg: FSM/mode types, Q-format constants and elaboration-time seed-table generators
package recip_pkg;
  typedef enum logic [2:0] {IDLE, MUL_A, MUL_B, MUL_C, DONE} state_t;
  typedef enum logic {MODE_RECIP, MODE_ISQRT} mode_t;
  function automatic logic [127:0] q_const(input int k, input int frac);
    return 128'(k) << frac;
  endfunction
  function automatic logic [15:0] seed_recip(input int i, input int sb);
    logic [63:0] den;
    den = 64'((1 << (sb + 1)) + 2 * i + 1);
    return 16'((64'd1 << (17 + sb)) / den);
  endfunction
  function automatic logic [15:0] seed_isqrt(input int i, input int sb);
    logic [63:0] den, lim, y, t;
    den = 64'((1 << (sb + 1)) + 2 * i + 1);
    lim = 64'd1 << (33 + sb);
    y = '0;
    for (int b = 15; b >= 0; b--) begin
      t = y | (64'd1 << b);
      if (t * t * den <= lim) y = t;
    end
    return 16'(y);
  endfunction
endpackage

// File: rtl/nr_mul_q.sv
// nr_mul_q: combinational signed Q-format multiply, full product floored back to Q format
module nr_mul_q #(
  parameter int Q_WIDTH = 64,
  parameter int Q_FRAC  = 55
) (
  input  logic [Q_WIDTH-1:0] a,
  input  logic [Q_WIDTH-1:0] b,
  output logic [Q_WIDTH-1:0] p
);
  logic [2*Q_WIDTH-1:0] full;
  assign full = {{Q_WIDTH{a[Q_WIDTH-1]}}, a} * {{Q_WIDTH{b[Q_WIDTH-1]}}, b};
  assign p = Q_WIDTH'(full >> Q_FRAC);
endmodule

// File: rtl/nr_recip_unit.sv
// nr_recip_unit: Newton-Raphson reciprocal / inverse-sqrt engine with LUT seed and one shared multiplier
module nr_recip_unit
  import recip_pkg::*;
#(
  parameter int Q_INT     = 9,
  parameter int Q_FRAC    = 55,
  parameter int Q_WIDTH   = Q_INT + Q_FRAC,
  parameter int MAX_ITER  = 4,
  parameter int SEED_BITS = 6,
  parameter int TAG_W     = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [Q_WIDTH-1:0]            in_d,
  input  logic                          in_mode,
  input  logic [$clog2(MAX_ITER+1)-1:0] in_iter,
  input  logic [TAG_W-1:0]              in_tag,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [Q_WIDTH-1:0]            out_result,
  output logic [TAG_W-1:0]              out_tag,
  output logic                          out_dz,
  output logic                          out_range_err
);
  localparam int IW = $clog2(MAX_ITER + 1);
  localparam int NS = 2 ** SEED_BITS;
  localparam logic [Q_WIDTH-1:0] ONE   = Q_WIDTH'(q_const(1, Q_FRAC));
  localparam logic [Q_WIDTH-1:0] TWO   = Q_WIDTH'(q_const(2, Q_FRAC));
  localparam logic [Q_WIDTH-1:0] THREE = Q_WIDTH'(q_const(3, Q_FRAC));
  localparam logic [Q_WIDTH-1:0] MAXP  = {1'b0, {(Q_WIDTH-1){1'b1}}};
  localparam logic [IW-1:0] NMAX = IW'(MAX_ITER);
  state_t state;
  mode_t mode_q;
  logic [Q_WIDTH-1:0] d_q, x_q, t_q, ma, mb, p, seed_x, half;
  logic [IW-1:0] cnt;
  logic dz_q, re_q, in_dz, in_re, isq;
  logic [15:0] lut [2][NS];
  for (genvar i = 0; i < NS; i++) begin : g_lut
    localparam logic [15:0] R = seed_recip(i, SEED_BITS);
    localparam logic [15:0] S = seed_isqrt(i, SEED_BITS);
    assign lut[0][i] = R;
    assign lut[1][i] = S;
  end
  assign in_ready = (state == IDLE) & ~reset;
  assign seed_x = Q_WIDTH'(lut[in_mode][in_d[Q_FRAC-1 -: SEED_BITS]]) << (Q_FRAC - 16);
  assign in_dz = in_d == '0;
  assign in_re = ~in_dz & (($signed(in_d) < $signed(ONE)) | ($signed(in_d) >= $signed(TWO)));
  assign isq = mode_q == MODE_ISQRT;
  assign half = $signed(THREE - t_q) >>> 1;
  always_comb begin
    ma = state == MUL_A ? (isq ? x_q : d_q) : (state == MUL_B && isq) ? d_q : x_q;
    mb = state == MUL_A ? x_q : state == MUL_C ? half : isq ? t_q : TWO - t_q;
  end
  nr_mul_q #(.Q_WIDTH(Q_WIDTH), .Q_FRAC(Q_FRAC)) u_mul (.a(ma), .b(mb), .p(p));
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      out_valid <= 1'b0;
      out_result <= '0;
      out_tag <= '0;
      out_dz <= 1'b0;
      out_range_err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          d_q <= in_d;
          mode_q <= mode_t'(in_mode);
          out_tag <= in_tag;
          cnt <= in_iter > NMAX ? NMAX : in_iter;
          x_q <= seed_x;
          dz_q <= in_dz;
          re_q <= in_re;
          out_dz <= 1'b0;
          out_range_err <= 1'b0;
          state <= MUL_A;
        end
        MUL_A: if (dz_q | re_q | (cnt == '0)) begin
          out_valid <= 1'b1;
          out_result <= dz_q ? MAXP : re_q ? '0 : x_q;
          out_dz <= dz_q;
          out_range_err <= re_q;
          state <= DONE;
        end else begin
          t_q <= p;
          state <= MUL_B;
        end
        MUL_B, MUL_C: if (state == MUL_B && isq) begin
          t_q <= p;
          state <= MUL_C;
        end else begin
          x_q <= p;
          cnt <= cnt - IW'(1);
          if (cnt == IW'(1)) begin
            out_valid <= 1'b1;
            out_result <= p;
            state <= DONE;
          end else state <= MUL_A;
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nr_recip_unit.sv
// tb_nr_recip_unit: directed scoreboard bench for nr_recip_unit
module tb_nr_recip_unit;
  localparam logic [63:0] ONE_Q = 64'h0080_0000_0000_0000;
  typedef struct {
    logic [63:0] res;
    longint      tol;
    logic [3:0]  tag;
    logic        dz;
    logic        re;
    int          lat;
    int          acc;
  } exp_t;
  logic clk = 1'b0, reset = 1'b1;
  logic in_valid = 1'b0, in_ready, in_mode = 1'b0, out_valid, out_ready = 1'b1, out_dz, out_range_err;
  logic [63:0] in_d = '0, out_result, held_r;
  logic [2:0] in_iter = '0;
  logic [3:0] in_tag = '0, out_tag, held_t;
  logic prev_v = 1'b0;
  int checks = 0, errors = 0, cyc = 0;
  exp_t sb[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  nr_recip_unit dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_d(in_d),
    .in_mode(in_mode), .in_iter(in_iter), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_tag(out_tag), .out_dz(out_dz),
    .out_range_err(out_range_err)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask
  task automatic chk_tol(input string name, input logic [63:0] act, input logic [63:0] req, input longint tol);
    longint diff;
    diff = $signed(act) - $signed(req);
    checks++;
    if (diff > tol || diff < -tol) begin
      errors++;
      $display("FAIL %s actual=%h required=%h tol=%0d", name, act, req, tol);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (out_valid && !prev_v) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output actual=%h tag=%h required=none", out_result, out_tag);
      end else begin
        e = sb.pop_front();
        chk_tol("result", out_result, e.res, e.tol);
        chk("tag", 64'(out_tag), 64'(e.tag));
        chk("dz", 64'(out_dz), 64'(e.dz));
        chk("range_err", 64'(out_range_err), 64'(e.re));
        chk("latency", 64'(cyc - e.acc), 64'(e.lat));
      end
      held_r = out_result;
      held_t = out_tag;
    end else if (out_valid && !out_ready) begin
      chk("hold_result", out_result, held_r);
      chk("hold_tag", 64'(out_tag), 64'(held_t));
      chk("hold_in_ready", 64'(in_ready), 64'(0));
    end
    prev_v = out_valid;
  end
  task automatic send(input logic [63:0] d, input logic m, input logic [2:0] it, input logic [3:0] tg,
                      input logic [63:0] res, input longint tol, input logic dz, input logic re, input int lat);
    exp_t e;
    int n = 0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_d = d; in_mode = m; in_iter = it; in_tag = tg;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=in_ready_low required=in_ready_high");
    end else begin
      e = '{res: res, tol: tol, tag: tg, dz: dz, re: re, lat: lat, acc: cyc + 1};
      sb.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask
  task automatic wait_done();
    int n = 0;
    while ((sb.size() != 0 || !in_ready) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL result_timeout actual=pending:%0d required=0", sb.size());
    end
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end
  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_result", out_result, 64'(0));
    chk("rst_out_tag", 64'(out_tag), 64'(0));
    chk("rst_out_dz", 64'(out_dz), 64'(0));
    chk("rst_out_range_err", 64'(out_range_err), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    reset = 1'b0;
    @(posedge clk); #1;
    chk("idle_in_ready", 64'(in_ready), 64'(1));
    send(64'h00C0_0000_0000_0000, 1'b0, 3'd4, 4'h5, 64'h0055_5555_5555_5555, 32, 1'b0, 1'b0, 8);
    wait_done();
    send(64'h00A0_0000_0000_0000, 1'b0, 3'd4, 4'h2, 64'h0066_6666_6666_6666, 32, 1'b0, 1'b0, 8);
    wait_done();
    send(ONE_Q, 1'b1, 3'd4, 4'h6, ONE_Q, 32, 1'b0, 1'b0, 12);
    wait_done();
    send(64'h00FF_FFFF_FFFF_FFFF, 1'b1, 3'd4, 4'h7, 64'h005A_8279_99FC_EF32, 32, 1'b0, 1'b0, 12);
    wait_done();
    send(64'h0, 1'b0, 3'd4, 4'h8, 64'h7FFF_FFFF_FFFF_FFFF, 0, 1'b1, 1'b0, 1);
    wait_done();
    send(64'h0140_0000_0000_0000, 1'b0, 3'd4, 4'h9, 64'h0, 0, 1'b0, 1'b1, 1);
    wait_done();
    send(64'hFF80_0000_0000_0000, 1'b1, 3'd4, 4'hB, 64'h0, 0, 1'b0, 1'b1, 1);
    wait_done();
    send(64'h0100_0000_0000_0000, 1'b0, 3'd2, 4'hC, 64'h0, 0, 1'b0, 1'b1, 1);
    wait_done();
    send(64'h00C0_0000_0000_0000, 1'b0, 3'd0, 4'hD, 64'd43464 << 39, 0, 1'b0, 1'b0, 1);
    wait_done();
    send(64'h00C0_0000_0000_0000, 1'b0, 3'd7, 4'hE, 64'h0055_5555_5555_5555, 32, 1'b0, 1'b0, 8);
    wait_done();
    out_ready = 1'b0;
    send(64'h00A0_0000_0000_0000, 1'b0, 3'd4, 4'h3, 64'h0066_6666_6666_6666, 32, 1'b0, 1'b0, 8);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("hold_reached", 64'(out_valid), 64'(1));
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0]; in_tag = 4'hF; in_d = 64'h00C0_0000_0000_0000; in_mode = 1'b0; in_iter = 3'd1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_out_valid", 64'(out_valid), 64'(0));
    chk("release_in_ready", 64'(in_ready), 64'(1));
    wait_done();
    @(posedge clk); #1;
    in_d = 64'h00C0_0000_0000_0000; in_mode = 1'b1; in_iter = 3'd4; in_tag = 4'h9; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst_out_valid", 64'(out_valid), 64'(0));
    chk("midrst_out_result", out_result, 64'(0));
    chk("midrst_in_ready", 64'(in_ready), 64'(0));
    reset = 1'b0;
    #1;
    chk("postrst_in_ready", 64'(in_ready), 64'(1));
    repeat (20) @(posedge clk);
    send(ONE_Q, 1'b1, 3'd4, 4'hA, ONE_Q, 32, 1'b0, 1'b0, 12);
    wait_done();
    chk("scoreboard_empty", 64'(sb.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
